param_tx: RTL and testbench

- Serialises the current generator settings (shape, frequency, offset, amplitude) into a UART byte frame on request, in the same byte order the command receiver parses.
- Drives the tx side of the shared uart unit (wr_uart / w_data / tx_full), so the host can read back the active configuration.
- Supports a loopback self-test: the receiver consumes the transmitter's frame unchanged.
- Runs entirely on clk_1MHz. The only cross-domain input is tx_full, which is synchronised internally.

---
 rtl/param_tx_pkg.sv | 59 +++++
 rtl/param_tx_sync_2ff.sv | 25 ++
 rtl/param_tx.sv | 153 +++++++++++++++
 tb/tb_param_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_tx_pkg.sv
// param_tx shared definitions: frame layout, header default,
// state encoding and payload byte selection.
package param_tx_pkg;

  localparam int PAYLOAD_LEN = 7;

  localparam logic [3:0] IDX_SHAPE  = 4'd0;
  localparam logic [3:0] IDX_FREQ_H = 4'd1;
  localparam logic [3:0] IDX_FREQ_L = 4'd2;
  localparam logic [3:0] IDX_OFF_H  = 4'd3;
  localparam logic [3:0] IDX_OFF_L  = 4'd4;
  localparam logic [3:0] IDX_AMP_H  = 4'd5;
  localparam logic [3:0] IDX_AMP_L  = 4'd6;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_WRITE = 3'd2;
  localparam state_t S_GAP   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  typedef struct packed {
    logic [7:0]  shape;
    logic [15:0] freq;
    logic [15:0] offs;
    logic [15:0] amp;
  } params_t;

  // Payload byte at a given payload index, receiver byte order.
  function automatic logic [7:0] payload_byte(
    input logic [3:0] idx,
    input params_t    p
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (idx)
      IDX_SHAPE:  b = p.shape;
      IDX_FREQ_H: b = p.freq[15:8];
      IDX_FREQ_L: b = p.freq[7:0];
      IDX_OFF_H:  b = p.offs[15:8];
      IDX_OFF_L:  b = p.offs[7:0];
      IDX_AMP_H:  b = p.amp[15:8];
      IDX_AMP_L:  b = p.amp[7:0];
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

  // XOR of the seven payload bytes.
  function automatic logic [7:0] payload_chk(input params_t p);
    return p.shape ^ p.freq[15:8] ^ p.freq[7:0]
         ^ p.offs[15:8] ^ p.offs[7:0]
         ^ p.amp[15:8] ^ p.amp[7:0];
  endfunction

endpackage

// File: rtl/param_tx_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with
// selectable reset value.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Two flops in series; both load RST_VAL on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/param_tx.sv
// param_tx: serialises the active generator settings
// into a UART byte frame on the uart tx write port.
module param_tx
  import param_tx_pkg::*;
#(
  parameter bit         HDR_EN     = 1'b0,
  parameter logic [7:0] HDR_BYTE   = DEF_HDR_BYTE,
  parameter bit         CHK_EN     = 1'b0,
  parameter int         GAP_CYCLES = 3
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        send,
  input  logic [7:0]  var_1,
  input  logic [15:0] var_2,
  input  logic [15:0] var_3,
  input  logic [15:0] var_4,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        done
);

  localparam int FRAME_LEN =
    PAYLOAD_LEN + int'(HDR_EN) + int'(CHK_EN);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [3:0] HDR_OFF  = 4'(HDR_EN);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state, state_n;
  logic [3:0]    idx, idx_n;
  logic [GW-1:0] gap_cnt, gap_n;
  params_t       snap;
  logic          load;
  logic          wr_n, busy_n, done_n;
  logic [7:0]    data_n;
  logic [7:0]    frame_byte;
  logic          tx_full_s;
  logic          gap_done;
  logic          last;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_full (
    .clk (clk_1MHz),
    .rst (rst),
    .d   (tx_full),
    .q   (tx_full_s)
  );

  assign gap_done = (gap_cnt == GAP_LAST);
  assign last     = (idx == LAST_IDX);

  // Byte for the current index: header, payload or checksum.
  always_comb begin
    frame_byte = payload_byte(idx - HDR_OFF, snap);
    if (HDR_EN && idx == 4'd0) begin
      frame_byte = HDR_BYTE;
    end else if (CHK_EN && last) begin
      frame_byte = payload_chk(snap);
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 4'd0;
      gap_cnt <= '0;
      snap    <= '0;
      wr_uart <= 1'b0;
      w_data  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      gap_cnt <= gap_n;
      wr_uart <= wr_n;
      w_data  <= data_n;
      busy    <= busy_n;
      done    <= done_n;
      if (load) begin
        snap <= '{var_1, var_2, var_3, var_4};
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (send) state_n = S_WAIT;
      S_WAIT:  if (!tx_full_s) state_n = S_WRITE;
      S_WRITE: state_n = S_GAP;
      S_GAP: begin
        if (gap_done) begin
          state_n = last ? S_DONE : S_WAIT;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of registered outputs and counters.
  always_comb begin
    idx_n  = idx;
    gap_n  = gap_cnt;
    load   = 1'b0;
    wr_n   = 1'b0;
    data_n = w_data;
    busy_n = busy;
    done_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (send) begin
          load   = 1'b1;
          idx_n  = 4'd0;
          busy_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (!tx_full_s) begin
          data_n = frame_byte;
          wr_n   = 1'b1;
        end
      end
      S_WRITE: gap_n = '0;
      S_GAP: begin
        if (gap_done) begin
          gap_n = '0;
          if (last) begin
            busy_n = 1'b0;
            done_n = 1'b1;
          end else begin
            idx_n = idx + 4'd1;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      S_DONE: idx_n = 4'd0;
      default: begin
        idx_n  = 4'd0;
        busy_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_param_tx.sv
// Scoreboard bench for param_tx: plain and
// header+checksum instances, loopback receiver model.
`timescale 1ns/1ps
module tb_param_tx;

  logic        clk_1MHz = 1'b0;
  logic        rst0, rst1, send0, send1;
  logic        tx_full0, tx_full1;
  logic [7:0]  var_1;
  logic [15:0] var_2, var_3, var_4;
  logic        wr0, wr1, busy0, busy1, done0, done1;
  logic [7:0]  wd0, wd1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int s0[$];
  int s1[$];
  int d0 = 0, d1 = 0, dcyc0 = 0, dcyc1 = 0;

  logic [7:0]  rxbuf[$];
  logic [7:0]  rx_v1;
  logic [15:0] rx_v2, rx_v3, rx_v4;
  int rx_cnt = 0;

  always #500 clk_1MHz = ~clk_1MHz;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  param_tx u_dut0 (
    .clk_1MHz (clk_1MHz), .rst (rst0), .send (send0),
    .var_1 (var_1), .var_2 (var_2), .var_3 (var_3),
    .var_4 (var_4), .tx_full (tx_full0), .wr_uart (wr0),
    .w_data (wd0), .busy (busy0), .done (done0)
  );

  param_tx #(
    .HDR_EN (1'b1), .HDR_BYTE (8'hA5), .CHK_EN (1'b1),
    .GAP_CYCLES (3)
  ) u_dut1 (
    .clk_1MHz (clk_1MHz), .rst (rst1), .send (send1),
    .var_1 (var_1), .var_2 (var_2), .var_3 (var_3),
    .var_4 (var_4), .tx_full (tx_full1), .wr_uart (wr1),
    .w_data (wd1), .busy (busy1), .done (done1)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act,
                           input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  task automatic mon_step();
    logic [7:0] e;
    if (rst0) rxbuf.delete();
    if (wr0) begin
      s0.push_back(cyc);
      if (q0.size() == 0) begin
        check("dut0 unexpected strobe", 32'(wd0), 32'hFFFF_FFFF);
      end else begin
        e = q0.pop_front();
        check("dut0 byte", 32'(wd0), 32'(e));
      end
      rxbuf.push_back(wd0);
      if (rxbuf.size() == 7) begin
        rx_v1 = rxbuf[0];
        rx_v2 = {rxbuf[1], rxbuf[2]};
        rx_v3 = {rxbuf[3], rxbuf[4]};
        rx_v4 = {rxbuf[5], rxbuf[6]};
        rx_cnt++;
        rxbuf.delete();
      end
    end
    if (done0) begin
      d0++;
      dcyc0 = cyc;
      check("dut0 busy at done", 32'(busy0), 32'd0);
    end
    if (wr1) begin
      s1.push_back(cyc);
      if (q1.size() == 0) begin
        check("dut1 unexpected strobe", 32'(wd1), 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        check("dut1 byte", 32'(wd1), 32'(e));
      end
    end
    if (done1) begin
      d1++;
      dcyc1 = cyc;
      check("dut1 busy at done", 32'(busy1), 32'd0);
    end
  endtask

  task automatic push0(input logic [7:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    q0.push_back(a);
    q0.push_back(b[15:8]);
    q0.push_back(b[7:0]);
    q0.push_back(c[15:8]);
    q0.push_back(c[7:0]);
    q0.push_back(d[15:8]);
    q0.push_back(d[7:0]);
  endtask

  task automatic pulse0(output int sc);
    @(negedge clk_1MHz);
    send0 = 1'b1;
    sc = cyc;
    @(negedge clk_1MHz);
    send0 = 1'b0;
  endtask

  task automatic wait_done0();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_1MHz);
      if (done0) return;
    end
    check("dut0 done timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done1();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_1MHz);
      if (done1) return;
    end
    check("dut1 done timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_strobes0(input int n);
    int k;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_1MHz);
      if (wr0) k++;
      if (k == n) return;
    end
    check("dut0 strobe timeout", 32'(k), 32'(n));
  endtask

  task automatic settle();
    @(posedge clk_1MHz);
    #1;
  endtask

  initial begin
    int sc, base, rel, dd, bs, rp;
    logic [7:0] exp1 [9];
    exp1 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h80,
             8'h00, 8'h0F, 8'hFF, 8'h54};
    fork
      forever begin
        @(negedge clk_1MHz);
        mon_step();
      end
    join_none

    rst0 = 1'b1; rst1 = 1'b1;
    send0 = 1'b1; send1 = 1'b1;
    tx_full0 = 1'b0; tx_full1 = 1'b0;
    var_1 = 8'h02; var_2 = 16'h1234;
    var_3 = 16'h8000; var_4 = 16'h0FFF;

    // 1: reset with send held high
    repeat (5) begin
      @(negedge clk_1MHz);
      check("reset outs dut0", {wr0, busy0, done0, wd0}, 32'd0);
      check("reset outs dut1", {wr1, busy1, done1, wd1}, 32'd0);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    send0 = 1'b0; send1 = 1'b0;
    repeat (5) @(negedge clk_1MHz);
    settle();
    check("no frame after reset", 32'(s0.size()), 32'd0);
    check("busy idle after reset", 32'(busy0), 32'd0);

    // 2: default frame, latency and spacing
    q0.push_back(8'h02); q0.push_back(8'h12);
    q0.push_back(8'h34); q0.push_back(8'h80);
    q0.push_back(8'h00); q0.push_back(8'h0F);
    q0.push_back(8'hFF);
    pulse0(sc);
    wait_done0();
    settle();
    check("frame strobes", 32'(s0.size()), 32'd7);
    check("first latency", 32'(s0[0] - sc), 32'd2);
    for (int i = 1; i < 7; i++)
      check("strobe spacing", 32'(s0[i] - s0[i-1]), 32'd5);
    check("done after last gap", 32'(dcyc0 - s0[6]), 32'd4);
    check("done count", 32'(d0), 32'd1);
    check("queue drained", 32'(q0.size()), 32'd0);

    // 3: back-pressure after third strobe
    base = s0.size();
    push0(8'h02, 16'h1234, 16'h8000, 16'h0FFF);
    pulse0(sc);
    wait_strobes0(3);
    tx_full0 = 1'b1;
    repeat (40) @(negedge clk_1MHz);
    settle();
    check("stall no strobe", 32'(s0.size()), 32'(base + 3));
    @(negedge clk_1MHz);
    tx_full0 = 1'b0;
    rel = cyc;
    wait_done0();
    settle();
    check("bp frame strobes", 32'(s0.size()), 32'(base + 7));
    check_rng("release latency", s0[base+3] - rel, 2, 4);
    check("bp queue drained", 32'(q0.size()), 32'd0);
    check("bp done count", 32'(d0), 32'd2);

    // 4: header and checksum frame
    foreach (exp1[i]) q1.push_back(exp1[i]);
    @(negedge clk_1MHz);
    send1 = 1'b1;
    @(negedge clk_1MHz);
    send1 = 1'b0;
    wait_done1();
    settle();
    check("hdr frame strobes", 32'(s1.size()), 32'd9);
    check("hdr frame span", 32'(s1[8] - s1[0]), 32'd40);
    check("hdr queue drained", 32'(q1.size()), 32'd0);
    check("hdr done count", 32'(d1), 32'd1);

    // 5a: send and var change mid-frame, send in done
    base = s0.size();
    dd = d0;
    push0(8'h02, 16'h1234, 16'h8000, 16'h0FFF);
    pulse0(sc);
    wait_strobes0(2);
    send0 = 1'b1;
    var_2 = 16'hFFFF;
    @(negedge clk_1MHz);
    send0 = 1'b0;
    wait_done0();
    send0 = 1'b1;
    @(negedge clk_1MHz);
    send0 = 1'b0;
    repeat (20) @(negedge clk_1MHz);
    settle();
    check("ignored send strobes", 32'(s0.size()), 32'(base + 7));
    check("single done", 32'(d0), 32'(dd + 1));
    check("snapshot queue", 32'(q0.size()), 32'd0);
    var_2 = 16'h1234;

    // 5b: reset mid-frame then restart
    base = s0.size();
    dd = d0;
    push0(8'h02, 16'h1234, 16'h8000, 16'h0FFF);
    pulse0(sc);
    wait_strobes0(4);
    rst0 = 1'b1;
    repeat (2) begin
      @(negedge clk_1MHz);
      check("wr in reset", 32'(wr0), 32'd0);
    end
    rst0 = 1'b0;
    q0.delete();
    repeat (10) @(negedge clk_1MHz);
    settle();
    bs = s0.size();
    check("abort strobes", 32'(bs), 32'(base + 4));
    check("abort no done", 32'(d0), 32'(dd));
    push0(8'h02, 16'h1234, 16'h8000, 16'h0FFF);
    pulse0(sc);
    wait_done0();
    settle();
    check("restart strobes", 32'(s0.size()), 32'(bs + 7));
    check("restart queue", 32'(q0.size()), 32'd0);
    check("restart done", 32'(d0), 32'(dd + 1));

    // 6: loopback into receiver model
    rp = rx_cnt;
    var_1 = 8'h03; var_2 = 16'hABCD;
    var_3 = 16'h0001; var_4 = 16'h7F00;
    push0(8'h03, 16'hABCD, 16'h0001, 16'h7F00);
    pulse0(sc);
    wait_done0();
    settle();
    check("rx var_1", 32'(rx_v1), 32'h03);
    check("rx var_2", 32'(rx_v2), 32'hABCD);
    check("rx var_3", 32'(rx_v3), 32'h0001);
    check("rx var_4", 32'(rx_v4), 32'h7F00);
    check("rx data_ready once", 32'(rx_cnt), 32'(rp + 1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
